// File: rtl/div_seq_32.sv
// ============================================================================
// div_seq_32 : iterative signed restoring divider, one quotient bit per cycle
// Revision   : 1.0
// ============================================================================
`default_nettype none

module div_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_result_rdy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_last_count = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] c_int_min    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH:0]     r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [CNT_W-1:0]   r_count;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_remainder;
    logic               r_exception;

    logic               w_accept;
    logic               w_div_zero;
    logic               w_last;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_rem_next;
    logic [WIDTH-1:0]   w_quo_next;

    assign w_accept   = ctrl_div && (r_state != RUN);
    assign w_div_zero = (operand_b == '0);
    assign w_last     = (r_count == c_last_count);
    assign w_abs_a    = operand_a[WIDTH-1] ? (~operand_a + 1'b1) : operand_a;
    assign w_abs_b    = operand_b[WIDTH-1] ? (~operand_b + 1'b1) : operand_b;

    // R never exceeds |b| <= 2^(WIDTH-1), so its top bit is always zero before the shift
    assign w_shift    = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_divisor};
    assign w_rem_next = w_trial[WIDTH] ? w_shift : w_trial;
    assign w_quo_next = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (ctrl_div) begin
                    w_state_next = w_div_zero ? DONE : RUN;
                end else begin
                    w_state_next = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_divisor   <= '0;
            r_count     <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_ovf       <= 1'b0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
        end else if (w_accept) begin
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_count   <= '0;
            r_q_neg   <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
            r_r_neg   <= operand_a[WIDTH-1];
            r_ovf     <= (operand_a == c_int_min) && (operand_b == '1);
            if (w_div_zero) begin
                r_result    <= '0;
                r_remainder <= '0;
                r_exception <= 1'b1;
            end
        end else if (r_state == RUN) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count + 1'b1;
            // Results are loaded from the final iteration so they are valid throughout DONE
            if (w_last) begin
                r_result    <= r_q_neg ? (~w_quo_next + 1'b1) : w_quo_next;
                r_remainder <= r_r_neg ? (~w_rem_next[WIDTH-1:0] + 1'b1)
                                       : w_rem_next[WIDTH-1:0];
                r_exception <= r_ovf;
            end
        end
    end

    assign busy            = (r_state == RUN);
    assign data_result_rdy = (r_state == DONE);
    assign data_result     = r_result;
    assign data_remainder  = r_remainder;
    assign data_exception  = r_exception;

endmodule

`default_nettype wire

// File: tb/tb_div_seq_32.sv
// ============================================================================
// tb_div_seq_32 : directed self-checking bench for div_seq_32
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_div_seq_32;

    logic        clock;
    logic        reset_n;
    logic        ctrl_div;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_result_rdy;

    int checks = 0;
    int errors = 0;

    div_seq_32 #(.WIDTH(32)) u_dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .ctrl_div        (ctrl_div),
        .operand_a       (operand_a),
        .operand_b       (operand_b),
        .busy            (busy),
        .data_result     (data_result),
        .data_remainder  (data_remainder),
        .data_exception  (data_exception),
        .data_result_rdy (data_result_rdy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Presents a request in cycle 0; returns just after the edge starting cycle 1
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(posedge clock);
        #1;
        ctrl_div  = 1'b1;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        ctrl_div  = 1'b0;
    endtask

    // Returns at the negedge of the rdy cycle; lat is that cycle's number
    task automatic wait_rdy(input int start, output int lat, output int nbusy);
        lat   = start;
        nbusy = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (busy) nbusy++;
            if (data_result_rdy) return;
            @(posedge clock);
            #1;
            lat++;
        end
        check("rdy_timeout", 32'd1, 32'd0);
        lat = -1;
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_e);
        int lat;
        int nbusy;
        issue(a, b);
        wait_rdy(1, lat, nbusy);
        check({tag, "_lat"},  32'(lat),   (b == 0) ? 32'd1 : 32'd33);
        check({tag, "_busy"}, 32'(nbusy), (b == 0) ? 32'd0 : 32'd32);
        check({tag, "_q"},    data_result,    exp_q);
        check({tag, "_r"},    data_remainder, exp_r);
        check({tag, "_exc"},  {31'd0, data_exception}, {31'd0, exp_e});
        check({tag, "_busy_at_rdy"}, {31'd0, busy}, 32'd0);
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rdy_drop"}, {31'd0, data_result_rdy}, 32'd0);
        check({tag, "_q_hold"},   data_result, exp_q);
    endtask

    initial begin
        int lat;
        int nbusy;
        int rdy_seen;

        reset_n   = 1'b0;
        ctrl_div  = 1'b0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdy",  {31'd0, data_result_rdy}, 32'd0);
        check("rst_q",    data_result, 32'd0);
        check("rst_r",    data_remainder, 32'd0);
        check("rst_exc",  {31'd0, data_exception}, 32'd0);
        reset_n = 1'b1;

        run("pos",     32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
        run("neg_a",   32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        run("neg_b",   32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0);
        run("dz",      32'd5,         32'd0,         32'd0,         32'd0,         1'b1);
        run("ovf",     32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b1);
        run("min_by2", 32'h8000_0000, 32'd2,         32'hC000_0000, 32'd0,         1'b0);
        run("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0);

        // Request during RUN (cycle 5) must be ignored
        issue(32'd100, 32'd7);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        ctrl_div  = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd3;
        @(posedge clock);
        #1;
        ctrl_div  = 1'b0;
        wait_rdy(6, lat, nbusy);
        check("ign_lat", 32'(lat), 32'd33);
        check("ign_q",   data_result, 32'd14);
        check("ign_r",   data_remainder, 32'd2);

        // Back-to-back request presented during DONE
        ctrl_div  = 1'b1;
        operand_a = 32'd9;
        operand_b = 32'd3;
        @(posedge clock);
        #1;
        ctrl_div  = 1'b0;
        wait_rdy(34, lat, nbusy);
        check("b2b_lat", 32'(lat), 32'd66);
        check("b2b_q",   data_result, 32'd3);
        check("b2b_r",   data_remainder, 32'd0);

        // Reset in cycle 10 aborts the division
        issue(32'd100, 32'd7);
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_q",    data_result, 32'd0);
        check("abort_r",    data_remainder, 32'd0);
        check("abort_exc",  {31'd0, data_exception}, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_result_rdy || busy) rdy_seen++;
        end
        check("abort_no_rdy", 32'(rdy_seen), 32'd0);

        issue(32'd12, 32'd5);
        wait_rdy(1, lat, nbusy);
        check("post_lat", 32'(lat), 32'd33);
        check("post_q",   data_result, 32'd2);
        check("post_r",   data_remainder, 32'd2);
        check("post_exc", {31'd0, data_exception}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
